// File: rtl/move_drain_unit.sv
// move_drain_unit: drains column move FIFOs after their done flags and streams the two
// 19-bit move slots of each word onto a valid/ready interface, counting emitted moves.
module move_drain_unit #(
  parameter int NCOL  = 8,
  parameter int MOVEW = 19,
  parameter int WORDW = 48,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCOL-1:0]       col_done,
  input  logic [NCOL-1:0]       col_empty,
  input  logic [NCOL*WORDW-1:0] col_data,
  output logic [NCOL-1:0]       col_rden,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [MOVEW-1:0]      move_data,
  output logic [CNTW-1:0]       move_count,
  output logic                  busy,
  output logic                  all_done
);
  localparam int PW = $clog2(NCOL);
  typedef enum logic [2:0] {IDLE, SCAN, READ, WAIT, EMIT0, EMIT1, DONE} state_t;
  state_t state, nxt;
  logic [NCOL-1:0] drained, pend;
  logic [PW-1:0] ptr, scan_ptr;
  logic [2*MOVEW-1:0] word;
  logic found, hs, restart, unused_col_bits;
  assign unused_col_bits = ^col_data;
  assign pend = col_done & ~drained;
  assign found = |pend;
  assign hs = move_valid & move_ready;
  assign restart = start & (state == IDLE | state == DONE);
  always_comb begin
    scan_ptr = '0;
    for (int i = NCOL - 1; i >= 0; i--) if (pend[i]) scan_ptr = i[PW-1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? SCAN : IDLE;
      SCAN:    nxt = !found ? (&drained ? DONE : SCAN) : (col_empty[scan_ptr] ? SCAN : READ);
      READ:    nxt = WAIT;
      WAIT:    nxt = EMIT0;
      EMIT0:   nxt = (word[MOVEW-1] | move_ready) ? EMIT1 : EMIT0;
      EMIT1:   nxt = (word[2*MOVEW-1] | move_ready) ? SCAN : EMIT1;
      DONE:    nxt = start ? SCAN : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    col_rden   = state == READ ? NCOL'(1) << ptr : '0;
    move_valid = (state == EMIT0 & ~word[MOVEW-1]) | (state == EMIT1 & ~word[2*MOVEW-1]);
    move_data  = state == EMIT0 ? word[MOVEW-1:0] : state == EMIT1 ? word[2*MOVEW-1:MOVEW] : '0;
    busy       = state != IDLE & state != DONE;
    all_done   = state == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      drained    <= '0;
      ptr        <= '0;
      word       <= '0;
      move_count <= '0;
    end else begin
      if (restart) begin
        drained    <= '0;
        move_count <= '0;
      end else if (hs && move_count != '1) move_count <= move_count + 1'b1;
      if (state == SCAN && found) begin
        ptr <= scan_ptr;
        if (col_empty[scan_ptr]) drained[scan_ptr] <= 1'b1;
      end
      if (state == WAIT) word <= col_data[ptr*WORDW +: 2*MOVEW];
    end
endmodule

// File: doc/move_drain_unit.md
Name: move_drain_unit

Overview:
- Board-level reader at the far end of the column move FIFOs.
- Waits for each column's done flag, then pops that column's 48-bit FIFO words.
- Unpacks the two 19-bit move slots in each word and presents them one at a time on a valid/ready stream to the move-selection logic.
- Counts emitted moves and raises all_done once all eight columns are drained.

Parameters:
NCOL, 8, number of columns drained (one per board file)
MOVEW, 19, move width: [18]invalid [17]promote [16]pawn move [15]pawn 2 sq [14]en passant [13]castle [12]capture [11:6]from [5:0]to
WORDW, 48, column FIFO word width; slot0 = [18:0], slot1 = [37:19], [47:38] ignored
CNTW, 8, move counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
start  in  1  one-cycle pulse; begins a new drain pass (accepted in IDLE or DONE only)
col_done  in  NCOL  per-column done flag; bit i = column xpos i
col_empty  in  NCOL  per-column FIFO empty flag
col_data  in  NCOL*WORDW  column FIFO read data; column i at [i*WORDW +: WORDW]
col_rden  out  NCOL  one-hot read enable, at most one bit high per cycle
move_valid  out  1  move_data holds a valid move
move_ready  in  1  consumer accepts when valid & ready
move_data  out  MOVEW  current move
move_count  out  CNTW  moves emitted this pass, saturating
busy  out  1  high in every state except IDLE and DONE
all_done  out  1  high in DONE

Behaviour:
Reset values (reset=0): state=IDLE, col_rden=0, move_valid=0, move_data=0, move_count=0, drained flags=0, word register=0, ptr=0.

FIFO read timing: col_rden[i] high for one cycle; col_data slice i is valid in the following cycle and is captured at that cycle's edge.

States:
- IDLE: outputs quiet. start -> SCAN; clears drained[7:0] and move_count.
- SCAN: ptr = lowest i with col_done[i] & ~drained[i].
  - No such i and drained all-ones -> DONE.
  - No such i otherwise -> stay in SCAN.
  - col_empty[ptr]=1 -> set drained[ptr], stay in SCAN. One column is examined per cycle.
  - Otherwise -> READ.
- READ: col_rden[ptr]=1 for exactly this cycle -> WAIT.
- WAIT: capture col_data slice ptr into word register -> EMIT0.
- EMIT0: if word[18]=1, skip to EMIT1 in one cycle with move_valid=0. Else move_valid=1, move_data=word[18:0]; hold both stable until move_ready; on handshake move_count+=1 and go to EMIT1.
- EMIT1: same rule applied to word[37:19]. On completion -> SCAN. SCAN re-tests the same column's empty flag, so a column is drained word by word.
- DONE: all_done=1, move_valid=0. start -> SCAN with a fresh pass; otherwise hold.

Arithmetic and ordering rules:
- move_count saturates at 2^CNTW-1 and does not wrap.
- A slot with bit 18 set is never emitted and never counted.
- move_valid never drops without a handshake, and move_data never changes while valid & ~ready.
- Columns are serviced lowest index first. A column whose done arrives late is picked up on a later SCAN.
- A column whose done flag drops after drained is set stays drained.

Boundary cases:
- start asserted while busy is ignored.
- move_ready high with move_valid low has no effect.
- reset asserted mid-pass aborts immediately: no further col_rden, and any pending move is discarded.
- Back-to-back words: from EMIT1 the path SCAN->READ->WAIT->EMIT0 takes 3 cycles before the next move can be valid.

Test Plan:
1. Reset then idle: reset=0 with random inputs -> col_rden=0, move_valid=0, move_count=0, all_done=0. Release with start=0 -> remains in IDLE.
2. Single column: col 3 holds one word with slot0=19'h0_0A1C and slot1 invalid (bit 18 set); all other columns done and empty; start, move_ready=1. Expect:
   - col_rden=8'h08 for exactly one cycle.
   - One move 0x00A1C emitted.
   - move_count=1, then all_done=1.
3. Backpressure: two valid slots in col 0; hold move_ready=0 for 5 cycles -> move_valid and move_data stable throughout. Release -> both moves delivered in order slot0, slot1; count=2.
4. Staggered done: columns 0-7 go done at cycles 10, 20, ..., 80, each with one word -> reads occur in index order, each only after that column's done; all_done follows the last drain.
5. Saturation: feed 140 words with both slots valid (280 moves) -> move_count sticks at 255, all moves still emitted.
6. Reset mid-pass: assert reset during EMIT0 with move_valid=1 -> move_valid=0 asynchronously, state=IDLE. A subsequent start performs a clean pass with count restarting at 0.
